// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
package pipe_adder_pkg;

    // Operation select carried on the op input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/adder_slice.sv
// One SW-bit slice of the ripple-pipelined adder.
// Exposes the carry into the slice MSB so the top slice can flag signed overflow.
module adder_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          c_in,
    output logic [SW-1:0] sum,
    output logic          c_out,
    output logic          c_top
);

    logic [SW:0] total;

    // Full-width slice add; carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c_in};
        sum   = total[SW-1:0];
        c_out = total[SW];
        c_top = a[SW-1] ^ b[SW-1] ^ total[SW-1];
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined W-bit adder/subtractor: one SW-bit slice per stage, with the
// unprocessed operand slices and completed sum slices riding along with each beat.
// A single global stall freezes every stage while the output is back-pressured.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int W      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int SW = W / STAGES;

    logic         stall;
    logic [W-1:0] b_eff;
    logic         c_eff;

    // Stage inputs (what stage k consumes this cycle).
    logic         in_v  [STAGES];
    logic [W-1:0] in_a  [STAGES];
    logic [W-1:0] in_b  [STAGES];
    logic [W-1:0] in_s  [STAGES];
    logic         in_c  [STAGES];
    logic         in_op [STAGES];

    // Stage register outputs.
    logic         st_v   [STAGES];
    logic [W-1:0] st_a   [STAGES];
    logic [W-1:0] st_b   [STAGES];
    logic [W-1:0] st_s   [STAGES];
    logic         st_c   [STAGES];
    logic         st_op  [STAGES];
    logic         st_ovf [STAGES];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Subtract is a + ~b + ~borrow_in; the carry is inverted again at the output.
    always_comb begin
        b_eff = b;
        c_eff = c_in;
        if (op == OP_SUB) begin
            b_eff = ~b;
            c_eff = ~c_in;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          v_q;
        logic [W-1:0]  a_q;
        logic [W-1:0]  b_q;
        logic [W-1:0]  s_q;
        logic          c_q;
        logic          op_q;
        logic          ovf_q;
        logic [W-1:0]  s_nxt;
        logic [SW-1:0] sl_sum;
        logic          sl_co;
        logic          sl_top;

        if (k == 0) begin : g_head
            assign in_v[k]  = in_valid;
            assign in_a[k]  = a;
            assign in_b[k]  = b_eff;
            assign in_s[k]  = '0;
            assign in_c[k]  = c_eff;
            assign in_op[k] = op;
        end else begin : g_link
            assign in_v[k]  = st_v[k-1];
            assign in_a[k]  = st_a[k-1];
            assign in_b[k]  = st_b[k-1];
            assign in_s[k]  = st_s[k-1];
            assign in_c[k]  = st_c[k-1];
            assign in_op[k] = st_op[k-1];
        end

        adder_slice #(
            .SW(SW)
        ) u_slice (
            .a     (in_a[k][k*SW +: SW]),
            .b     (in_b[k][k*SW +: SW]),
            .c_in  (in_c[k]),
            .sum   (sl_sum),
            .c_out (sl_co),
            .c_top (sl_top)
        );

        // Merge this stage's slice result into the partial sum travelling with the beat.
        always_comb begin
            s_nxt                = in_s[k];
            s_nxt[k*SW +: SW]    = sl_sum;
        end

        // Stage register: cleared by reset, frozen on stall, otherwise advances.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                c_q   <= 1'b0;
                op_q  <= 1'b0;
                ovf_q <= 1'b0;
            end else if (!stall) begin
                v_q   <= in_v[k];
                a_q   <= in_a[k];
                b_q   <= in_b[k];
                s_q   <= s_nxt;
                c_q   <= sl_co;
                op_q  <= in_op[k];
                ovf_q <= sl_top ^ sl_co;
            end
        end

        assign st_v[k]   = v_q;
        assign st_a[k]   = a_q;
        assign st_b[k]   = b_q;
        assign st_s[k]   = s_q;
        assign st_c[k]   = c_q;
        assign st_op[k]  = op_q;
        assign st_ovf[k] = ovf_q;
    end

    assign out_valid = st_v[STAGES-1];
    assign sum       = st_s[STAGES-1];
    assign c_out     = st_c[STAGES-1] ^ st_op[STAGES-1];
    assign ovf       = st_ovf[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (W = 16, STAGES = 4).
module tb_pipe_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    pipe_adder #(
        .W      (16),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, confirm exactly 4-cycle latency and the result, then drain.
    task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic tc, input logic top,
                           input logic [15:0] es, input logic ec, input logic eo);
        a        = ta;
        b        = tb_v;
        c_in     = tc;
        op       = top;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check({tag, "_early_valid"}, out_valid, 0);
            tick();
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_c_out"}, c_out, ec);
        check({tag, "_ovf"}, ovf, eo);
        tick();
        check({tag, "_drain"}, out_valid, 0);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        int          next_in;
        int          got;
        bit          in_stall;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        op        = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 16'h0000);
        check("reset_c_out", c_out, 0);
        check("reset_ovf", ovf, 0);
        check("reset_in_ready", in_ready, 1);

        // Directed arithmetic vectors.
        run_one("add_1_1_c1",    16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
        run_one("add_ffff_1",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("add_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("add_0fff_1",    16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_one("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_one("sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        run_one("sub_8000_1",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        run_one("sub_10_3_b1",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b0);
        run_one("sub_0_0_b1",    16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Stream 8 beats a=i, b=10*i (i=1..8) with out_ready low in cycles 6..8.
        next_in = 0;
        got     = 0;
        c_in    = 1'b0;
        op      = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            in_stall  = (cyc >= 6 && cyc <= 8);
            out_ready = !in_stall;
            if (next_in < 8) begin
                in_valid = 1'b1;
                a        = 16'(next_in + 1);
                b        = 16'(10 * (next_in + 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_stall) begin
                check("stream_stall_in_ready", in_ready, 0);
                check("stream_stall_valid", out_valid, 1);
                check("stream_stall_sum_held", sum, 16'd33);
            end else begin
                check("stream_in_ready", in_ready, 1);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_out", out_valid, 0);
                end else begin
                    check("stream_sum", sum, exp_q[0]);
                    check("stream_c_out", c_out, 0);
                    check("stream_ovf", ovf, 0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && !in_stall) begin
                exp_q.push_back(16'(11 * (next_in + 1)));
                next_in++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_results_count", got, 8);
        check("stream_accepted_count", next_in, 8);

        // Mid-stream reset: 3 accepted beats plus one offered with rst must all vanish.
        out_ready = 1'b1;
        op        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'(100 + i);
            b        = 16'h0000;
            tick();
        end
        rst = 1'b1;
        a   = 16'h0AAA;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_sum", sum, 16'h0000);
        check("rst_mid_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            check("rst_mid_quiet", out_valid, 0);
            tick();
        end
        run_one("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Reset while stalled: clears the held result and reopens in_ready.
        out_ready = 1'b0;
        a         = 16'h0002;
        b         = 16'h0003;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("stalled_valid", out_valid, 1);
        check("stalled_sum", sum, 16'h0005);
        check("stalled_in_ready", in_ready, 0);
        tick();
        check("stalled_hold_sum", sum, 16'h0005);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_stall_out_valid", out_valid, 0);
        check("rst_stall_sum", sum, 16'h0000);
        check("rst_stall_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
